// File: rtl/seg_display_mux.sv
// Four-digit multiplexed seven-segment driver: latches BCD digits and decimal points,
// then scans them onto a shared active-low segment bus with active-low anodes.
module seg_display_mux #(
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        en,
  output logic [6:0]  y,
  output logic        dp,
  output logic [3:0]  control
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [3:0]       digit_reg [4];
  logic [3:0]       dp_reg;

  logic       tick_c;
  logic [3:0] cur_digit_c;
  logic       blank_c;
  logic [6:0] glyph_c;
  logic [3:0] anode_c;

  // Slot decode: selected digit, leading-zero blanking, glyph and anode
  always_comb begin
    tick_c      = (cnt == CNT_MAX);
    cur_digit_c = digit_reg[idx];
    blank_c     = 1'b0;
    glyph_c     = 7'b0111111;
    anode_c     = 4'b1111;

    unique case (idx)
      2'd0: blank_c = 1'b0;
      2'd1: blank_c = (digit_reg[3] == 4'd0) && (digit_reg[2] == 4'd0) && (digit_reg[1] == 4'd0);
      2'd2: blank_c = (digit_reg[3] == 4'd0) && (digit_reg[2] == 4'd0);
      2'd3: blank_c = (digit_reg[3] == 4'd0);
      default: blank_c = 1'b0;
    endcase
    blank_c = blank_c && BLANK_LEADING;

    case (cur_digit_c)
      4'd0: glyph_c = 7'b1000000;
      4'd1: glyph_c = 7'b1111001;
      4'd2: glyph_c = 7'b0100100;
      4'd3: glyph_c = 7'b0110000;
      4'd4: glyph_c = 7'b0011001;
      4'd5: glyph_c = 7'b0010010;
      4'd6: glyph_c = 7'b0000010;
      4'd7: glyph_c = 7'b1111000;
      4'd8: glyph_c = 7'b0000000;
      4'd9: glyph_c = 7'b0011000;
      default: glyph_c = 7'b0111111;
    endcase

    unique case (idx)
      2'd0: anode_c = 4'b1110;
      2'd1: anode_c = 4'b1101;
      2'd2: anode_c = 4'b1011;
      2'd3: anode_c = 4'b0111;
      default: anode_c = 4'b1111;
    endcase
  end

  // Prescaler, slot index, digit latch and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= '0;
      dp_reg  <= '0;
      y       <= SEG_OFF;
      dp      <= 1'b1;
      control <= 4'b1111;
    end else begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      if (tick_c) idx <= idx + 2'd1;
      if (load) begin
        for (int i = 0; i < 4; i++) digit_reg[i] <= digits_in[i*4 +: 4];
        dp_reg <= dp_in;
      end
      if (en) begin
        control <= anode_c;
        y       <= blank_c ? SEG_OFF : glyph_c;
        dp      <= ~dp_reg[idx];
      end else begin
        control <= 4'b1111;
        y       <= SEG_OFF;
        dp      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux: a driver pushes model predictions per edge,
// a monitor pops and compares both the blanking and non-blanking instances.
module tb_seg_display_mux;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst, load, en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  y_a, y_b;
  logic        dp_a, dp_b;
  logic [3:0]  ctl_a, ctl_b;

  typedef struct packed {
    logic [6:0] y;
    logic       dp;
    logic [3:0] ctl;
  } out_t;

  out_t exp_a_q[$];
  out_t exp_b_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference state: latched digits, dps and edges elapsed since reset release
  int         m_dig [4];
  logic [3:0] m_dp;
  int         m_n;

  always #5 clk = ~clk;

  seg_display_mux #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) u_blank (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .en(en), .y(y_a), .dp(dp_a), .control(ctl_a)
  );

  seg_display_mux #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b0)) u_noblank (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .en(en), .y(y_b), .dp(dp_b), .control(ctl_b)
  );

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic out_t model_out(input bit blank_en);
    out_t o;
    int   slot, msd;
    o = '{y: 7'b1111111, dp: 1'b1, ctl: 4'b1111};
    if (!en) return o;
    slot = (m_n / DIV) % 4;
    msd  = -1;
    for (int p = 0; p < 4; p++) if (m_dig[p] != 0) msd = p;
    o.ctl = ~(4'b0001 << slot);
    o.dp  = ~m_dp[slot];
    o.y   = (blank_en && slot > 0 && slot > msd) ? 7'b1111111 : glyph(m_dig[slot]);
    return o;
  endfunction

  // One clock edge: predict, advance the model, let the edge happen
  task automatic cycle();
    out_t off;
    off = '{y: 7'b1111111, dp: 1'b1, ctl: 4'b1111};
    if (rst) begin
      exp_a_q.push_back(off);
      exp_b_q.push_back(off);
      m_n = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      m_dp = 4'b0000;
    end else begin
      exp_a_q.push_back(model_out(1'b1));
      exp_b_q.push_back(model_out(1'b0));
      m_n++;
      if (load) begin
        for (int i = 0; i < 4; i++) m_dig[i] = int'(digits_in[i*4 +: 4]);
        m_dp = dp_in;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load_once(input logic [15:0] d, input logic [3:0] p);
    digits_in = d;
    dp_in     = p;
    load      = 1'b1;
    cycle();
    load      = 1'b0;
  endtask

  function automatic void check(input string name, input out_t got, input out_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got y=%b dp=%b control=%b, expected y=%b dp=%b control=%b",
                  name, got.y, got.dp, got.ctl, exp.y, exp.dp, exp.ctl);
  endfunction

  // Monitor: outputs are valid every edge; compare against queued predictions
  always @(posedge clk) begin
    out_t ea, eb;
    #1;
    if (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front();
      check("blank_leading", {y_a, dp_a, ctl_a}, ea);
    end
    if (exp_b_q.size() > 0) begin
      eb = exp_b_q.pop_front();
      check("show_all", {y_b, dp_b, ctl_b}, eb);
    end
  end

  initial begin
    int bound;
    rst = 1'b1; load = 1'b0; en = 1'b1; digits_in = '0; dp_in = '0;
    m_n = 0; m_dp = '0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;

    run(2);
    rst = 1'b0;
    load_once(16'h1234, 4'b0100);
    run(20);
    load_once(16'h0042, 4'b0000);
    run(16);
    load_once(16'h0000, 4'b0000);
    run(16);
    load_once(16'h00A5, 4'b0001);
    run(16);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(16);

    // Reset in the middle of slot 2
    load_once(16'h5678, 4'b1010);
    bound = 0;
    while (((m_n / DIV) % 4) != 2 && bound < 64) begin
      cycle();
      bound++;
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(3);

    // Load coinciding with a tick edge
    bound = 0;
    while ((m_n % DIV) != DIV - 1 && bound < 16) begin
      cycle();
      bound++;
    end
    load_once(16'h9087, 4'b0110);
    run(12);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      en   = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < 4; k++)
        digits_in[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      dp_in = 4'($urandom_range(0, 15));
      cycle();
    end
    rst = 1'b0; load = 1'b0; en = 1'b1;
    run(4);

    #10;
    n_checks++;
    if (exp_a_q.size() == 0 && exp_b_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d/%0d predictions left, required 0/0",
                  exp_a_q.size(), exp_b_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
